// File: rtl/regfile_port_ctrl_if.sv
// Bundle of client handshakes and register-file port signals for regfile_port_ctrl.
// The slave modport is the controller's view; master is the clients' and register file's view.
interface regfile_port_ctrl_if #(
  parameter int REG_SZ = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [4:0]        op_rs;
  logic [4:0]        op_rt;
  logic              res_valid;
  logic              res_ready;
  logic [REG_SZ-1:0] res_a;
  logic [REG_SZ-1:0] res_b;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_idx;
  logic [REG_SZ-1:0] wb_data;
  logic              rf_re;
  logic [4:0]        rf_r_idx;
  logic [REG_SZ-1:0] rf_dout;
  logic              rf_we;
  logic [4:0]        rf_w_idx;
  logic [REG_SZ-1:0] rf_din;
  logic              busy;

  modport slave (
    input  op_valid, op_rs, op_rt, res_ready, wb_valid, wb_idx, wb_data, rf_dout,
    output op_ready, res_valid, res_a, res_b, wb_ready, rf_re, rf_r_idx,
           rf_we, rf_w_idx, rf_din, busy
  );

  modport master (
    output op_valid, op_rs, op_rt, res_ready, wb_valid, wb_idx, wb_data, rf_dout,
    input  op_ready, res_valid, res_a, res_b, wb_ready, rf_re, rf_r_idx,
           rf_we, rf_w_idx, rf_din, busy
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Shares the register file's single read and write ports between operand fetch and
// writeback, producing spaced one-cycle strobes and forcing register 0 to read as zero.
//
// state  | meaning
// IDLE   | waiting; buffered write has priority over a new fetch
// WR     | rf_we high for the buffered write
// WR_GAP | strobe-free cycle after a write
// RD_A   | rf_re high for rs
// GAP_A  | strobe-free cycle between the two reads
// RD_B   | rf_re high for rt
// RESP   | operands presented until res_ready
module regfile_port_ctrl #(
  parameter int REG_SZ = 32
) (
  input  logic               clk,
  input  logic               rst,
  regfile_port_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD_A, GAP_A, RD_B, RESP} state_t;

  state_t            state;
  logic              buf_full;
  logic [4:0]        buf_idx;
  logic [REG_SZ-1:0] buf_data;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic              wb_take;
  logic              op_take;

  // A pending writeback blocks fetch acceptance so earlier writes are always visible.
  assign bus.wb_ready = !buf_full;
  assign bus.op_ready = (state == IDLE) && !buf_full && !bus.wb_valid;
  assign bus.busy     = (state != IDLE) || buf_full;
  assign wb_take      = bus.wb_valid && !buf_full;
  assign op_take      = bus.op_valid && bus.op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      buf_full      <= 1'b0;
      buf_idx       <= '0;
      buf_data      <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      bus.rf_re     <= 1'b0;
      bus.rf_r_idx  <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_w_idx  <= '0;
      bus.rf_din    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_a     <= '0;
      bus.res_b     <= '0;
    end else begin
      if (wb_take) begin
        buf_full <= 1'b1;
        buf_idx  <= bus.wb_idx;
        buf_data <= bus.wb_data;
      end

      case (state)
        IDLE: begin
          if (buf_full) begin
            if (buf_idx != 5'd0) begin
              state        <= WR;
              bus.rf_we    <= 1'b1;
              bus.rf_w_idx <= buf_idx;
              bus.rf_din   <= buf_data;
            end else begin
              buf_full <= 1'b0;
            end
          end else if (op_take) begin
            rs_q <= bus.op_rs;
            rt_q <= bus.op_rt;
            if (bus.op_rs != 5'd0) begin
              state        <= RD_A;
              bus.rf_re    <= 1'b1;
              bus.rf_r_idx <= bus.op_rs;
            end else if (bus.op_rt != 5'd0) begin
              state        <= RD_B;
              bus.res_a    <= '0;
              bus.rf_re    <= 1'b1;
              bus.rf_r_idx <= bus.op_rt;
            end else begin
              state         <= RESP;
              bus.res_a     <= '0;
              bus.res_b     <= '0;
              bus.res_valid <= 1'b1;
            end
          end
        end
        WR: begin
          bus.rf_we <= 1'b0;
          buf_full  <= 1'b0;
          state     <= WR_GAP;
        end
        WR_GAP: state <= IDLE;
        RD_A: begin
          bus.rf_re <= 1'b0;
          bus.res_a <= bus.rf_dout;
          if (rt_q == rs_q) begin
            bus.res_b     <= bus.rf_dout;
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end else if (rt_q == 5'd0) begin
            bus.res_b     <= '0;
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end else begin
            state <= GAP_A;
          end
        end
        GAP_A: begin
          bus.rf_re    <= 1'b1;
          bus.rf_r_idx <= rt_q;
          state        <= RD_B;
        end
        RD_B: begin
          bus.rf_re     <= 1'b0;
          bus.res_b     <= bus.rf_dout;
          bus.res_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural register file and strobe monitor.
module tb_regfile_port_ctrl;

  logic clk = 1'b0;
  logic rst;

  regfile_port_ctrl_if #(.REG_SZ(32)) bus ();

  regfile_port_ctrl #(.REG_SZ(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Pulse-driven register file: read data only while rf_re is high.
  logic [31:0] mem [32];
  always @(posedge clk) if (bus.rf_we) mem[bus.rf_w_idx] <= bus.rf_din;
  assign bus.rf_dout = bus.rf_re ? mem[bus.rf_r_idx] : 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int viol_cnt = 0;
  int last_re_cyc = 0;
  int last_re_gap = 0;
  logic prev_strobe = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rf_re) begin
      re_cnt      <= re_cnt + 1;
      last_re_gap <= cyc - last_re_cyc;
      last_re_cyc <= cyc;
    end
    if (bus.rf_we) we_cnt <= we_cnt + 1;
    if ((bus.rf_re && bus.rf_we) || ((bus.rf_re || bus.rf_we) && prev_strobe))
      viol_cnt <= viol_cnt + 1;
    prev_strobe <= bus.rf_re || bus.rf_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_op_ready(input string tag);
    int w = 0;
    #1;
    while (!bus.op_ready && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    chk({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data,
                          input int exp_we, input string tag);
    int we0;
    we0 = we_cnt;
    bus.wb_valid = 1'b1;
    bus.wb_idx   = idx;
    bus.wb_data  = data;
    #1;
    chk({tag, "_wb_ready"}, 32'(bus.wb_ready), 32'd1);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    wait_op_ready(tag);
    chk({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  task automatic fetch(input logic [4:0] rs, input logic [4:0] rt, input int exp_lat,
                       input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input int exp_re, input string tag);
    int re0;
    int lat;
    bus.op_valid = 1'b1;
    bus.op_rs    = rs;
    bus.op_rt    = rt;
    wait_op_ready(tag);
    re0 = re_cnt;
    @(negedge clk);
    bus.op_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res_a"}, bus.res_a, exp_a);
    chk({tag, "_res_b"}, bus.res_b, exp_b);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_re_pulses"}, 32'(re_cnt - re0), 32'(exp_re));
  endtask

  initial begin
    int we0;
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_rs     = '0;
    bus.op_rt     = '0;
    bus.res_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_idx    = '0;
    bus.wb_data   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_rf_re", 32'(bus.rf_re), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_r_idx", 32'(bus.rf_r_idx), 32'd0);
    chk("rst_w_idx", 32'(bus.rf_w_idx), 32'd0);
    chk("rst_din", bus.rf_din, 32'd0);
    chk("rst_res_a", bus.res_a, 32'd0);
    chk("rst_res_b", bus.res_b, 32'd0);
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);

    // write r5 with explicit cycle timing, then fetch rs=5 rt=0
    we0 = we_cnt;
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 5'd5;
    bus.wb_data  = 32'h1234;
    #1;
    chk("t1_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("t1_op_blocked", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    chk("t1_busy_buf", 32'(bus.busy), 32'd1);
    chk("t1_wb_full", 32'(bus.wb_ready), 32'd0);
    chk("t1_we_early", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_w_idx", 32'(bus.rf_w_idx), 32'd5);
    chk("t1_din", bus.rf_din, 32'h1234);
    @(negedge clk);
    chk("t1_we_gap", 32'(bus.rf_we), 32'd0);
    chk("t1_gap_op_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    chk("t1_idle_op_ready", 32'(bus.op_ready), 32'd1);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    chk("t1_we_pulses", 32'(we_cnt - we0), 32'd1);
    fetch(5'd5, 5'd0, 2, 32'h1234, 32'h0, 1, "t1_fetch");
    chk("t1_r_idx_hold", 32'(bus.rf_r_idx), 32'd5);

    // two distinct reads
    do_write(5'd3, 32'h11, 1, "t2_w3");
    do_write(5'd7, 32'h22, 1, "t2_w7");
    fetch(5'd3, 5'd7, 4, 32'h11, 32'h22, 2, "t2_fetch");
    chk("t2_re_gap", 32'(last_re_gap), 32'd2);
    chk("t2_r_idx_hold", 32'(bus.rf_r_idx), 32'd7);

    // simultaneous write and fetch: write wins and is visible
    we0 = we_cnt;
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 5'd3;
    bus.wb_data  = 32'hAAAA;
    bus.op_valid = 1'b1;
    bus.op_rs    = 5'd3;
    bus.op_rt    = 5'd3;
    #1;
    chk("t3_op_ready_low", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    fetch(5'd3, 5'd3, 2, 32'hAAAA, 32'hAAAA, 1, "t3_fetch");
    chk("t3_we_pulses", 32'(we_cnt - we0), 32'd1);

    // register 0 writes are dropped and reads yield zero without strobes
    do_write(5'd0, 32'hFFFF, 0, "t4_w0");
    fetch(5'd0, 5'd0, 1, 32'h0, 32'h0, 0, "t4_fetch00");
    fetch(5'd0, 5'd7, 2, 32'h0, 32'h22, 1, "t4_fetch07");

    // hold RESP with res_ready low; buffer still accepts a write meanwhile
    bus.op_valid = 1'b1;
    bus.op_rs    = 5'd3;
    bus.op_rt    = 5'd7;
    wait_op_ready("t5");
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("t5_hold_a", bus.res_a, 32'hAAAA);
      chk("t5_hold_b", bus.res_b, 32'h22);
      chk("t5_hold_op_ready", 32'(bus.op_ready), 32'd0);
      if (i == 1) begin
        bus.wb_valid = 1'b1;
        bus.wb_idx   = 5'd7;
        bus.wb_data  = 32'h77;
        #1;
        chk("t5_resp_wb_ready", 32'(bus.wb_ready), 32'd1);
      end
      @(negedge clk);
      bus.wb_valid = 1'b0;
    end
    chk("t5_still_b", bus.res_b, 32'h22);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    fetch(5'd7, 5'd7, 2, 32'h77, 32'h77, 1, "t5_after");

    // reset during RD_B discards fetch and buffered write
    bus.op_valid = 1'b1;
    bus.op_rs    = 5'd3;
    bus.op_rt    = 5'd7;
    wait_op_ready("t6");
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_idx   = 5'd9;
    bus.wb_data  = 32'h99;
    #1;
    chk("t6_wb_ready_rda", 32'(bus.wb_ready), 32'd1);
    @(negedge clk);
    bus.wb_valid = 1'b0;
    chk("t6_wb_full", 32'(bus.wb_ready), 32'd0);
    @(negedge clk);
    chk("t6_rdb_re", 32'(bus.rf_re), 32'd1);
    chk("t6_rdb_idx", 32'(bus.rf_r_idx), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    we0 = we_cnt;
    chk("t6_rst_re", 32'(bus.rf_re), 32'd0);
    chk("t6_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_op_ready", 32'(bus.op_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("t6_no_stale_we", 32'(we_cnt - we0), 32'd0);

    chk("strobe_spacing_violations", 32'(viol_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
